// File: rtl/mem_arbiter.sv
// Two-port (CPU = port 0, DMA = port 1) arbiter for a single word-wide I/O bus, sequenced IDLE -> ACCESS -> DONE.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rdata,
  output logic [15:0] bus_dir,
  output logic        bus_oe,
  output logic [15:0] bus_wdata,
  output logic        bus_drive,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] bus_dir_q, bus_dir_d;
  logic        bus_oe_q, bus_oe_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic        bus_drive_q, bus_drive_d;
  logic        pick;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the port preferred on the next tie: the one not granted most recently.
  logic rr_q, rr_d;

  always_comb begin
    if (req0 && req1) pick = rr_q;
    else              pick = req1;
  end
`else
  always_comb pick = !req0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata_d     = rdata_q;
    bus_dir_d   = bus_dir_q;
    bus_oe_d    = bus_oe_q;
    bus_wdata_d = bus_wdata_q;
    bus_drive_d = bus_drive_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Latch the winner's request once; later changes on its inputs have no effect.
          state_d     = ACCESS;
          cnt_d       = WAIT_LOAD;
          gnt0_d      = !pick;
          gnt1_d      = pick;
          bus_dir_d   = pick ? addr1  : addr0;
          bus_oe_d    = pick ? we1    : we0;
          bus_drive_d = pick ? we1    : we0;
          bus_wdata_d = pick ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d        = !pick;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = DONE;
          gnt0_d      = 1'b0;
          gnt1_d      = 1'b0;
          done0_d     = gnt0_q;
          done1_d     = gnt1_q;
          bus_oe_d    = 1'b0;
          bus_drive_d = 1'b0;
          if (!bus_oe_q) rdata_d = bus_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata_q     <= 16'h0000;
      bus_dir_q   <= 16'h0000;
      bus_oe_q    <= 1'b0;
      bus_wdata_q <= 16'h0000;
      bus_drive_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata_q     <= rdata_d;
      bus_dir_q   <= bus_dir_d;
      bus_oe_q    <= bus_oe_d;
      bus_wdata_q <= bus_wdata_d;
      bus_drive_q <= bus_drive_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign bus_dir   = bus_dir_q;
  assign bus_oe    = bus_oe_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_drive = bus_drive_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, extra bus cycles per access (range 0..15).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request, port 0 (CPU) / port 1 (DMA).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  16 each  word address (0xFFFF = red LEDs, 0xFFFE = green LEDs, else SRAM).
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 gnt0, gnt1  output  1 each  port owns bus.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  16  read data, valid in the done cycle.
REQ-011 bus_dir  output  16  address to I/O manager.
REQ-012 bus_oe  output  1  write strobe to I/O manager (1 = write).
REQ-013 bus_wdata  output  16  write data to bus.
REQ-014 bus_drive  output  1  1 = arbiter drives data bus (writes only).
REQ-015 bus_rdata  input  16  data returned from bus.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
REQ-017 IDLE: any req -> winner chosen, gntN=1 registered next cycle, addr/we/wdata latched, state ACCESS.
REQ-018 ACCESS lasts WAIT_CYCLES+1 cycles via a 4-bit down counter; bus_dir/bus_oe/bus_wdata/bus_drive are constant for the whole phase.
REQ-019 Read: bus_rdata sampled into rdata on the last ACCESS cycle; rdata holds until the next read completes.
REQ-020 DONE: doneN=1 for exactly one cycle, gntN deasserts the same cycle, bus_oe=0, bus_drive=0; next state IDLE.
REQ-021 Request-to-done latency = WAIT_CYCLES+3 cycles; one idle cycle between back-to-back grants.
REQ-022 At most one gnt and at most one done high in any cycle.
REQ-023 Requester holds req and inputs until done; inputs changed after grant are ignored.
REQ-024 req dropped mid-ACCESS: access completes, done still pulses.
REQ-025 Simultaneous req0 and req1 in IDLE: resolved per REQ-032/033; loser keeps waiting, no request lost.
REQ-026 Addresses 0xFFFF/0xFFFE pass through unchanged; no decoding in this block.
REQ-027 WAIT_CYCLES=0: ACCESS lasts exactly 1 cycle.

Reset
REQ-028 reset asserted forces IDLE immediately regardless of clk, aborting any access.
REQ-029 Reset values: gnt0=gnt1=0, done0=done1=0, rdata=0, bus_dir=0, bus_oe=0, bus_wdata=0, bus_drive=0, counter=0, round-robin pointer = port 0 preferred.
REQ-030 An access aborted by reset produces no done pulse.
REQ-031 After reset deasserts, the first rising edge with req present starts arbitration normally.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted most recently wins; pointer updates on each grant.
REQ-033 ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins; no pointer register.

Verification
REQ-034 Single read: req0=1, we0=0, addr0=0x0010, bus_rdata=0xA5A5, WAIT_CYCLES=1 -> gnt0 next cycle, bus_dir=0x0010, bus_oe=0 for 2 cycles, done0 pulse with rdata=0xA5A5 at cycle 4.
REQ-035 Write to LEDs: req1=1, we1=1, addr1=0xFFFF, wdata1=0x03FF -> bus_dir=0xFFFF, bus_oe=1, bus_drive=1, bus_wdata=0x03FF during ACCESS; done1 single pulse.
REQ-036 Contention: req0=req1=1 held continuously, round robin -> grants alternate 0,1,0,1; macro undefined -> only port 0 granted.
REQ-037 Reset mid-ACCESS: assert reset during cycle 2 of a write -> all outputs at reset values within the cycle, no done pulse, state IDLE.
REQ-038 Request drop: req0 deasserted one cycle after gnt0 -> access completes, done0 pulses, then IDLE.
REQ-039 WAIT_CYCLES=0 read of 0x1234 with bus_rdata=0x5A5A -> done0 at cycle 3, rdata=0x5A5A.
